controlador_bcd_seq: RTL
========================

Name: controlador_bcd_seq

Overview:
- Sequential, time-shared binary-to-BCD conversion engine for the processor's display output path.
- Accepts 32-bit operands from two requesters over a Req/Ack handshake and arbitrates between them round-robin.
- Converts with the shift-and-add-3 algorithm, one bit per clock.
- Publishes 7 BCD digits plus an overflow flag and a one-cycle completion pulse.

Parameters:
- LARGURA, 32, operand width in bits and number of shift cycles.
- DIGITOS, 7, number of BCD digits produced.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  synchronous reset, active-low.
- ReqA  in  1  requester A asks for a conversion.
- DadoA  in  LARGURA  operand from requester A.
- AckA  out  1  one-cycle grant pulse to A; DadoA is captured at that edge.
- ReqB  in  1  requester B asks for a conversion.
- DadoB  in  LARGURA  operand from requester B.
- AckB  out  1  one-cycle grant pulse to B.
- Ocupado  out  1  high while a conversion is in progress.
- Pronto  out  1  one-cycle pulse: result registers were just updated.
- Origem  out  1  owner of the current result: 0 = A, 1 = B.
- Digitos  out  4*DIGITOS  BCD result; units in [3:0], most significant digit in the top nibble.
- Estouro  out  1  operand was at least 10^DIGITOS; Digitos hold the value mod 10^DIGITOS.

Behaviour:
- Reset (Resetn low at a rising edge):
  - State goes to OCIOSO.
  - AckA, AckB, Pronto, Ocupado, Origem, Estouro go to 0; Digitos to 0.
  - Round-robin pointer goes to A.
  - Reset overrides everything, including mid-conversion; a conversion in flight is discarded with no Pronto.
- States: OCIOSO, DESLOCA, FIM. Ocupado = (state != OCIOSO).
- OCIOSO, edge E0 with any Req high:
  - Grant one requester; latch its operand into the shift register.
  - Clear the internal BCD accumulator and the overflow sticky bit; set the bit counter to LARGURA-1.
  - Register Origem_interno; go to DESLOCA.
  - The granted Ack is high for exactly the cycle after E0.
- Arbitration:
  - If only one Req is high, that requester wins.
  - If both are high, the pointer's requester wins; after each grant the pointer moves to the other requester.
- DESLOCA, edges E1..E(LARGURA): each edge does one step.
  - Every digit >= 5 gets +3 (4-bit wrap-free, max 12).
  - The whole {BCD, operand} chain shifts left by 1.
  - The bit shifted out of the top digit is ORed into the overflow sticky.
  - The counter decrements. When the counter is 0 at the edge, go to FIM (at E32 for the default).
- FIM, next edge (E33):
  - Copy accumulator to Digitos, sticky to Estouro, Origem_interno to Origem.
  - Pronto is high for the cycle after E33; go to OCIOSO.
- Latency and throughput:
  - Pronto rises LARGURA+1 cycles after Ack.
  - Earliest next grant is at E34, i.e. one result per LARGURA+2 cycles.
- Outputs between conversions: Digitos, Estouro and Origem hold their last values until the next Pronto.
- Requester rules:
  - Hold Req and Dado stable until Ack. Dado may change the cycle after Ack.
  - Dropping Req before Ack withdraws the request.
  - Req high during Ocupado is neither acked nor lost; it is served when the state returns to OCIOSO.
  - Holding Req after Ack requests a new conversion.
- Never assert AckA and AckB together; never assert Ack outside the cycle after an OCIOSO grant edge.

Decomposition:
- Shared package holds:
  - state encoding (OCIOSO, DESLOCA, FIM);
  - LIMIAR_AJUSTE = 5 and AJUSTE = 3;
  - ORIGEM_A = 0 and ORIGEM_B = 1.
- One natural sub-module: ajuste_digito. It is combinational (4-bit in, 4-bit out, +3 when >= 5) and is instantiated DIGITOS times in the shift datapath.
- Controller and arbiter stay in controlador_bcd_seq.

Test Plan:
- Reset, then ReqA with DadoA=0 -> AckA one cycle; Pronto 33 cycles later; Digitos=0x0000000, Estouro=0, Origem=0.
- ReqB with DadoB=9999999 -> Digitos=0x9999999, Estouro=0, Origem=1; ReqB with DadoB=12345678 -> Digitos=0x2345678, Estouro=1; ReqB with DadoB=0xFFFFFFFF -> Digitos=0x4967295, Estouro=1.
- ReqA and ReqB both held high with DadoA=1234 and DadoB=56 from reset -> grants alternate A, B, A; Pronto results 0x0001234 (Origem 0), then 0x0000056 (Origem 1); grants 34 cycles apart; never both Acks high.
- ReqA pulsed during Ocupado while a B conversion runs -> no AckA until after Pronto; Digitos unchanged until that Pronto.
- Resetn low at edge E10 of a conversion of 4321 -> no Pronto; all outputs 0; ReqA for 4321 afterwards -> Digitos=0x0004321 after 33 cycles.
- ReqA raised then dropped before the grant edge while Ocupado -> no AckA, no extra conversion.

Source files
------------

// File: rtl/controlador_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit adjust constants and requester identifiers.
package controlador_bcd_seq_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam logic [3:0] LIMIAR_AJUSTE = 4'd5;
  localparam logic [3:0] AJUSTE        = 4'd3;

  localparam logic ORIGEM_A = 1'b0;
  localparam logic ORIGEM_B = 1'b1;

endpackage

// File: rtl/controlador_bcd_seq_ajuste.sv
// Add-3 correction for one BCD digit, applied before each shift of the
// double-dabble chain so the shifted digit carries correctly into the next.
module ajuste_digito
  import controlador_bcd_seq_pkg::*;
(
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= LIMIAR_AJUSTE) ? (digito_i + AJUSTE) : digito_i;

endmodule

// File: rtl/controlador_bcd_seq.sv
// Time-shared binary-to-BCD engine with two round-robin requesters; converts
// one operand bit per clock using shift-and-add-3.
module controlador_bcd_seq
  import controlador_bcd_seq_pkg::*;
#(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 7
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   ReqA,
  input  logic [LARGURA-1:0]     DadoA,
  output logic                   AckA,
  input  logic                   ReqB,
  input  logic [LARGURA-1:0]     DadoB,
  output logic                   AckB,
  output logic                   Ocupado,
  output logic                   Pronto,
  output logic                   Origem,
  output logic [4*DIGITOS-1:0]   Digitos,
  output logic                   Estouro
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   oper_q, oper_d;
  logic [4*DIGITOS-1:0] bcd_q, bcd_d;
  logic [4*DIGITOS-1:0] bcd_ajustado;
  logic                 sticky_q, sticky_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic                 origem_int_q, origem_int_d;
  logic                 ptr_q, ptr_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic                 pronto_q, pronto_d;
  logic                 origem_q, origem_d;
  logic                 estouro_q, estouro_d;
  logic [4*DIGITOS-1:0] digitos_q, digitos_d;
  logic                 escolhe_b;

  for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .digito_i (bcd_q[4*i +: 4]),
      .digito_o (bcd_ajustado[4*i +: 4])
    );
  end

  always_comb begin
    estado_d     = estado_q;
    oper_d       = oper_q;
    bcd_d        = bcd_q;
    sticky_d     = sticky_q;
    cont_d       = cont_q;
    origem_int_d = origem_int_q;
    ptr_d        = ptr_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    pronto_d     = 1'b0;
    origem_d     = origem_q;
    estouro_d    = estouro_q;
    digitos_d    = digitos_q;
    escolhe_b    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (ReqA || ReqB) begin
          // Pointer only matters on contention; the winner hands priority to the other side.
          escolhe_b    = ReqB && (!ReqA || (ptr_q == ORIGEM_B));
          oper_d       = escolhe_b ? DadoB : DadoA;
          bcd_d        = '0;
          sticky_d     = 1'b0;
          cont_d       = CW'(LARGURA - 1);
          origem_int_d = escolhe_b ? ORIGEM_B : ORIGEM_A;
          ptr_d        = escolhe_b ? ORIGEM_A : ORIGEM_B;
          ack_a_d      = !escolhe_b;
          ack_b_d      = escolhe_b;
          estado_d     = DESLOCA;
        end
      end
      DESLOCA: begin
        // Bits leaving the top digit mean the value passed 10^DIGITOS; keep them sticky.
        bcd_d    = {bcd_ajustado[4*DIGITOS-2:0], oper_q[LARGURA-1]};
        oper_d   = {oper_q[LARGURA-2:0], 1'b0};
        sticky_d = sticky_q | bcd_ajustado[4*DIGITOS-1];
        cont_d   = cont_q - CW'(1);
        if (cont_q == '0) begin
          estado_d = FIM;
        end
      end
      FIM: begin
        digitos_d = bcd_q;
        estouro_d = sticky_q;
        origem_d  = origem_int_q;
        pronto_d  = 1'b1;
        estado_d  = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      estado_q     <= OCIOSO;
      oper_q       <= '0;
      bcd_q        <= '0;
      sticky_q     <= 1'b0;
      cont_q       <= '0;
      origem_int_q <= ORIGEM_A;
      ptr_q        <= ORIGEM_A;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      pronto_q     <= 1'b0;
      origem_q     <= ORIGEM_A;
      estouro_q    <= 1'b0;
      digitos_q    <= '0;
    end else begin
      estado_q     <= estado_d;
      oper_q       <= oper_d;
      bcd_q        <= bcd_d;
      sticky_q     <= sticky_d;
      cont_q       <= cont_d;
      origem_int_q <= origem_int_d;
      ptr_q        <= ptr_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      pronto_q     <= pronto_d;
      origem_q     <= origem_d;
      estouro_q    <= estouro_d;
      digitos_q    <= digitos_d;
    end
  end

  assign AckA    = ack_a_q;
  assign AckB    = ack_b_q;
  assign Pronto  = pronto_q;
  assign Origem  = origem_q;
  assign Estouro = estouro_q;
  assign Digitos = digitos_q;
  assign Ocupado = (estado_q != OCIOSO);

endmodule
